soc_sysid_counter: RTL

- Parametrised successor to the SoC system-ID slave: an Avalon-MM slave that returns build identification words.
- Adds a free-running cycle counter with atomic 64-bit snapshot reads, overflow flag and interrupt, a control register, and software scratch registers.
- Sits on the Nios/HPS peripheral bus. Software uses it for ID checks and for timestamping cache-context switches.
- Single clock domain; fixed read latency of 1.

---
 rtl/soc_sysid_counter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/soc_sysid_counter.sv
// soc_sysid_counter
//   Avalon-MM slave returning build identification words, plus a free-running
//   cycle counter with coherent 64-bit snapshot reads, overflow flag/irq,
//   a control register and byte-maskable scratch registers.
//   No waitrequest; fixed read latency of 1.
//
// Ports
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   address        word address [ADDR_W]
//   read / write   one-cycle strobes
//   writedata      write data [32]
//   byteenable     write byte lanes [4]
//   readdata       registered read data [32], holds between reads
//   readdatavalid  one-cycle pulse, one clock after an accepted read
//   irq            registered level interrupt = OVF & OVF_IE
//
// Map: 0 SYSTEM_ID, 1 TIMESTAMP, 2 CAPS, 3 CTRL, 4 CNT_LO, 5 CNT_HI,
//      6..5+NUM_SCRATCH scratch, rest reads 0.
module soc_sysid_counter #(
  parameter logic [31:0] SYSTEM_ID   = 32'h63BE_2A11,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter int          ADDR_W      = 4,
  parameter int          NUM_SCRATCH = 4,
  parameter int          CNT_W       = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              irq
);

  localparam int HI_W  = CNT_W - 32;
  localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

  localparam logic [ADDR_W-1:0] A_SYSID = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TSTMP = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CAPS  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CNTLO = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CNTHI = ADDR_W'(5);

  localparam logic [31:0] CAPS = {8'h01, 8'(CNT_W), 8'(NUM_SCRATCH), 8'(ADDR_W)};

  logic [CNT_W-1:0] r_cnt;
  logic [HI_W-1:0]  r_snap;
  logic             r_en, r_ovf, r_ovf_ie;
  logic [31:0]      r_scr [SCR_N];
  logic [31:0]      r_rdata;
  logic             r_rvalid, r_irq;

  logic             w_ctrl_wr0;
  logic             w_clr;
  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_rd_mux;

  // CTRL bits all live in byte lane 0.
  assign w_ctrl_wr0 = write && (address == A_CTRL) && byteenable[0];
  assign w_clr      = w_ctrl_wr0 && writedata[1];
  // CLR beats increment, so a clear on the all-ones cycle is not a wrap.
  assign w_wrap     = r_en && !w_clr && (&r_cnt);
  assign w_cnt_nxt  = w_clr ? '0 : (r_en ? r_cnt + CNT_W'(1) : r_cnt);

  // Counter is reloaded every cycle (a hold is just reloading itself).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_en     <= 1'b1;
      r_ovf    <= 1'b0;
      r_ovf_ie <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_ctrl_wr0) begin
        r_en     <= writedata[0];
        r_ovf_ie <= writedata[3];
      end
      // Hardware set wins over a coincident W1C.
      if (w_wrap)                          r_ovf <= 1'b1;
      else if (w_ctrl_wr0 && writedata[2]) r_ovf <= 1'b0;
      r_irq <= r_ovf & r_ovf_ie;
    end
  end

  // Scratch registers, byte-lane masked.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SCR_N; i++) r_scr[i] <= '0;
    end else if (write) begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (address == ADDR_W'(6 + i))
          for (int b = 0; b < 4; b++)
            if (byteenable[b]) r_scr[i][8*b +: 8] <= writedata[8*b +: 8];
    end
  end

  // Read mux sees pre-write / pre-increment state, so a same-cycle write
  // or count edge never leaks into the returned word.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      A_SYSID: w_rd_mux = SYSTEM_ID;
      A_TSTMP: w_rd_mux = TIMESTAMP;
      A_CAPS:  w_rd_mux = CAPS;
      A_CTRL:  w_rd_mux = {28'd0, r_ovf_ie, r_ovf, 1'b0, r_en};
      A_CNTLO: w_rd_mux = r_cnt[31:0];
      A_CNTHI: w_rd_mux = 32'(r_snap);
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++)
          if (address == ADDR_W'(6 + i)) w_rd_mux = r_scr[i];
      end
    endcase
  end

  // Read response; CNT_LO read latches the upper counter bits from the same
  // pre-increment value so a following CNT_HI read is coherent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_snap   <= '0;
    end else begin
      r_rvalid <= read;
      if (read) begin
        r_rdata <= w_rd_mux;
        if (address == A_CNTLO) r_snap <= r_cnt[CNT_W-1:32];
      end
    end
  end

  assign readdata      = r_rdata;
  assign readdatavalid = r_rvalid;
  assign irq           = r_irq;

endmodule
